// File: rtl/mux4to1_case_if.sv
// Bundle of the mux data, select and observation signals. clk and rst stay
// plain module ports. The master side (the sources and the consumer) drives
// a..d and s; the slave side (the mux) drives every result. There is no
// valid/ready handshake: the inputs are sampled on every rising clk edge, and
// out follows them combinationally at all times.
// Optional feature macro: MUX4_PARITY_EN (adds out_par).
interface mux4to1_case_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] d;
    logic [1:0]       s;
    logic [WIDTH-1:0] out;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] sel_chg_cnt;
`ifdef MUX4_PARITY_EN
    logic             out_par;

    modport master (
        output a, b, c, d, s,
        input  out, out_q, sel_q, sel_chg_cnt, out_par
    );
    modport slave (
        input  a, b, c, d, s,
        output out, out_q, sel_q, sel_chg_cnt, out_par
    );
`else
    modport master (
        output a, b, c, d, s,
        input  out, out_q, sel_q, sel_chg_cnt
    );
    modport slave (
        input  a, b, c, d, s,
        output out, out_q, sel_q, sel_chg_cnt
    );
`endif
endinterface

// File: rtl/mux4to1_case.sv
// 4:1 WIDTH-bit case-decoded multiplexer. It has a zero-latency
// combinational output, a registered copy of that output, a registered copy
// of the select code, and a saturating counter of select changes.
// Optional feature macro: MUX4_PARITY_EN. When it is defined, the block adds
// the registered parity output out_par.
// The design has no FSM. Its whole observable state is on the bus:
// out_q, sel_q, sel_chg_cnt (and out_par when enabled).
module mux4to1_case #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input logic           clk,
    input logic           rst,
    mux4to1_case_if.slave bus
);

    logic [WIDTH-1:0] mux_d;
    logic [WIDTH-1:0] out_q;
    logic [1:0]       sel_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Case decode of the select code. Any unknown select bit falls through to
    // the default branch, so out is all zeros and no storage is implied.
    always_comb begin
        mux_d = '0;
        case (bus.s)
            2'b00:   mux_d = bus.a;
            2'b01:   mux_d = bus.b;
            2'b10:   mux_d = bus.c;
            2'b11:   mux_d = bus.d;
            default: mux_d = '0;
        endcase
    end

    // Next count value: add one when s differs from the registered select,
    // and hold at the all-ones value instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if ((bus.s != sel_q) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Registered path. Reset takes priority over every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            sel_q <= 2'b00;
            cnt_q <= '0;
        end else begin
            out_q <= mux_d;
            sel_q <= bus.s;
            cnt_q <= cnt_d;
        end
    end

`ifdef MUX4_PARITY_EN
    logic par_q;

    // Parity of the selected word. It is captured on the same edge as out_q,
    // so it has the same one-cycle latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= ^mux_d;
        end
    end

    assign bus.out_par = par_q;
`endif

    assign bus.out         = mux_d;
    assign bus.out_q       = out_q;
    assign bus.sel_q       = sel_q;
    assign bus.sel_chg_cnt = cnt_q;

endmodule

// File: tb/tb_mux4to1_case.sv
// Testbench for mux4to1_case. It instantiates two copies: u_dut uses the
// default counter width and u_sat uses CNT_W=2. Both copies see the same
// inputs. A behavioural model predicts every output from the written rules:
// an array lookup picks the selected word, and plain integers model the
// registers and the saturating counter.
module tb_mux4to1_case;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT_W = 2;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mux4to1_case_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) if0 ();
    mux4to1_case_if #(.WIDTH(WIDTH), .CNT_W(SAT_W)) if1 ();

    assign if1.a = if0.a;
    assign if1.b = if0.b;
    assign if1.c = if0.c;
    assign if1.d = if0.d;
    assign if1.s = if0.s;

    mux4to1_case #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    mux4to1_case #(.WIDTH(WIDTH), .CNT_W(SAT_W)) u_sat (
        .clk (clk),
        .rst (rst),
        .bus (if1)
    );

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int m_out_q = 0;
    int m_sel_q = 0;
    int m_cnt   = 0;
    int m_cnt2  = 0;
    int m_par   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Selected word, looked up directly from the current inputs.
    function automatic int pick();
        int words[4];
        words[0] = int'(if0.a);
        words[1] = int'(if0.b);
        words[2] = int'(if0.c);
        words[3] = int'(if0.d);
        return words[int'(if0.s)];
    endfunction

    // Parity of an integer word, computed bit by bit.
    function automatic int parity(input int v);
        int p;
        p = 0;
        for (int i = 0; i < WIDTH; i++) p = p ^ ((v >> i) & 1);
        return p;
    endfunction

    // ---------------- driver ----------------
    task automatic set_in(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                          input logic [3:0] d, input logic [1:0] s);
        if0.a = a;
        if0.b = b;
        if0.c = c;
        if0.d = d;
        if0.s = s;
    endtask

    // Step the model using the pre-edge inputs, apply one clock edge, then
    // compare every output.
    task automatic tick();
        int sel;
        sel = pick();
        if (rst) begin
            m_out_q = 0;
            m_sel_q = 0;
            m_cnt   = 0;
            m_cnt2  = 0;
            m_par   = 0;
        end else begin
            if (int'(if0.s) != m_sel_q) begin
                if (m_cnt  < (1 << CNT_W) - 1) m_cnt++;
                if (m_cnt2 < (1 << SAT_W) - 1) m_cnt2++;
            end
            m_out_q = sel;
            m_sel_q = int'(if0.s);
            m_par   = parity(sel);
        end
        @(posedge clk);
        #1;
        check("out",       32'(if0.out),         32'(pick()));
        check("out_q",     32'(if0.out_q),       32'(m_out_q));
        check("sel_q",     32'(if0.sel_q),       32'(m_sel_q));
        check("cnt",       32'(if0.sel_chg_cnt), 32'(m_cnt));
        check("sat_out_q", 32'(if1.out_q),       32'(m_out_q));
        check("sat_sel_q", 32'(if1.sel_q),       32'(m_sel_q));
        check("sat_cnt",   32'(if1.sel_chg_cnt), 32'(m_cnt2));
`ifdef MUX4_PARITY_EN
        check("out_par",   32'(if0.out_par),     32'(m_par));
`endif
    endtask

    typedef struct {
        logic [3:0] a, b, c, d;
        logic [1:0] s;
        logic [3:0] exp_out;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [1:0] s_cur;

        // Expected values below come from the select table:
        // 00->a, 01->b, 10->c, 11->d.
        vecs[0] = '{4'h1, 4'h2, 4'h3, 4'h0, 2'b00, 4'h1};
        vecs[1] = '{4'h1, 4'h2, 4'h3, 4'h0, 2'b01, 4'h2};
        vecs[2] = '{4'h1, 4'h2, 4'h3, 4'h0, 2'b10, 4'h3};
        vecs[3] = '{4'h1, 4'h2, 4'h3, 4'h0, 2'b11, 4'h0};
        vecs[4] = '{4'hF, 4'h0, 4'h0, 4'h0, 2'b00, 4'hF};
        vecs[5] = '{4'h0, 4'hA, 4'h5, 4'hC, 2'b01, 4'hA};
        vecs[6] = '{4'h0, 4'hA, 4'h5, 4'hC, 2'b10, 4'h5};
        vecs[7] = '{4'h0, 4'hA, 4'h5, 4'hC, 2'b11, 4'hC};
        vecs[8] = '{4'h8, 4'h9, 4'hE, 4'hF, 2'b11, 4'hF};
        vecs[9] = '{4'h8, 4'h9, 4'hE, 4'h7, 2'b11, 4'h7};

        rst = 1'b1;
        set_in(4'h0, 4'h0, 4'h0, 4'h0, 2'b00);

        // Combinational path: each result appears with no clock edge.
        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d, vecs[i].s);
            #1;
            check("comb_vec", 32'(if0.out), 32'(vecs[i].exp_out));
        end

        // Reset for two edges, then the first edge with s=11 and d=3.
        #2;
        rst = 1'b1;
        tick();
        tick();
        check("rst_out_q", 32'(if0.out_q), 32'h0);
        check("rst_sel_q", 32'(if0.sel_q), 32'h0);
        check("rst_cnt",   32'(if0.sel_chg_cnt), 32'h0);
        rst = 1'b0;
        set_in(4'h1, 4'h2, 4'h5, 4'h3, 2'b11);
        tick();
        check("first_out_q", 32'(if0.out_q), 32'h3);
        check("first_sel_q", 32'(if0.sel_q), 32'h3);
        check("first_cnt",   32'(if0.sel_chg_cnt), 32'h1);

        // Ten edges, each with a select different from the previous one,
        // then five edges holding s constant.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        s_cur = 2'b00;
        for (int i = 0; i < 10; i++) begin
            s_cur = s_cur + 2'b01;
            if0.s = s_cur;
            tick();
        end
        check("ten_changes", 32'(if0.sel_chg_cnt), 32'd10);
        check("sat_at_3",    32'(if1.sel_chg_cnt), 32'd3);
        for (int i = 0; i < 5; i++) tick();
        check("hold_cnt",    32'(if0.sel_chg_cnt), 32'd10);

        // Reset in the middle of toggling, with the count at 5. The
        // combinational output stays live while reset is held.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if0.s = ~if0.s;
            tick();
        end
        check("cnt_five", 32'(if0.sel_chg_cnt), 32'd5);
        rst = 1'b1;
        if0.s = ~if0.s;
        tick();
        check("midrst_cnt",   32'(if0.sel_chg_cnt), 32'd0);
        check("midrst_out_q", 32'(if0.out_q), 32'd0);
        set_in(4'h6, 4'h7, 4'h9, 4'hB, 2'b10);
        #1;
        check("midrst_live", 32'(if0.out), 32'h9);
        rst = 1'b0;
        tick();

`ifdef MUX4_PARITY_EN
        // Parity: 0111 is odd parity, 0011 is even parity.
        set_in(4'h0, 4'b0111, 4'h0, 4'h0, 2'b01);
        tick();
        check("par_odd",  32'(if0.out_par), 32'd1);
        if0.b = 4'b0011;
        tick();
        check("par_even", 32'(if0.out_par), 32'd0);
`endif

        // Randomized inputs, with an occasional reset.
        for (int i = 0; i < 300; i++) begin
            set_in(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   2'($urandom_range(0, 3)));
            rst = ($urandom_range(0, 24) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
